// File: rtl/strawman_pkg.sv
// Shared definitions for the strawman chiplet protocol: flit/command codes,
// responder state encoding, header field positions and flit builders.
package strawman_pkg;

  localparam int RESP_FLIT_W = 40;

  localparam logic [1:0] FLIT_HDR  = 2'b00;
  localparam logic [1:0] FLIT_DATA = 2'b10;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;

  localparam logic [2:0] RCMD_RD_RESP = 3'b101;
  localparam logic [2:0] RCMD_WR_ACK  = 3'b110;
  localparam logic [2:0] RCMD_ERR     = 3'b111;

  localparam int FLIT_TYPE_LSB = 38;
  localparam int HDR_RCMD_LSB  = 35;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_TAG_LSB   = 26;
  localparam int DATA_IDX_LSB  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WDATA    = 3'd2,
    ST_RESP_HDR = 3'd3,
    ST_RDATA    = 3'd4
  } resp_state_e;

  function automatic logic [RESP_FLIT_W-1:0] build_hdr(input logic [2:0] rcmd,
                                                       input logic [2:0] len,
                                                       input logic [5:0] tag);
    logic [RESP_FLIT_W-1:0] f;
    f = {RESP_FLIT_W{1'b0}};
    f[FLIT_TYPE_LSB +: 2] = FLIT_HDR;
    f[HDR_RCMD_LSB +: 3]  = rcmd;
    f[HDR_LEN_LSB +: 3]   = len;
    f[HDR_TAG_LSB +: 6]   = tag;
    return f;
  endfunction

  function automatic logic [RESP_FLIT_W-1:0] build_data(input logic [5:0] idx,
                                                        input logic [31:0] data);
    logic [RESP_FLIT_W-1:0] f;
    f = {RESP_FLIT_W{1'b0}};
    f[FLIT_TYPE_LSB +: 2] = FLIT_DATA;
    f[DATA_IDX_LSB +: 6]  = idx;
    f[31:0]               = data;
    return f;
  endfunction

endpackage

// File: rtl/strawman_credit_counter.sv
// Saturating up/down credit counter with a registered nonzero flag; shared by
// the responder and the TX FSMs.
module strawman_credit_counter #(
  parameter int MAX   = 32,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             nonzero
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_s;
  logic             nonzero_r;

  // Next count: a concurrent return and spend cancel; a return at MAX is dropped.
  always_comb begin
    next_s = count_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r != WIDTH'(MAX)) begin
          next_s = count_r + WIDTH'(1);
        end else begin
          next_s = count_r;
        end
      end
      2'b01:   next_s = count_r - WIDTH'(1);
      default: next_s = count_r;
    endcase
  end

  // Count and nonzero flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= WIDTH'(MAX);
      nonzero_r <= (WIDTH'(MAX) != WIDTH'(0));
    end else begin
      count_r   <= next_s;
      nonzero_r <= (next_s != WIDTH'(0));
    end
  end

  assign count   = count_r;
  assign nonzero = nonzero_r;

endmodule

// File: rtl/strawman_slave_responder.sv
// Slave-side responder: executes decoded read/write requests against a local
// register file and emits credit-gated response flits.
module strawman_slave_responder
  import strawman_pkg::*;
#(
  parameter int FLIT_WIDTH   = 40,
  parameter int ADDR_BITS    = 6,
  parameter int CREDITS      = 32,
  parameter int CREDIT_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              i_cmd,
  input  logic                    i_cmd_valid,
  input  logic [2:0]              i_length,
  input  logic [5:0]              i_feature0,
  input  logic [31:0]             i_addr,
  input  logic                    i_addr_valid,
  input  logic [31:0]             i_data,
  input  logic                    i_data_valid,
  output logic                    o_rx_ready,
  output logic [FLIT_WIDTH-1:0]   o_flit,
  output logic                    o_flit_valid,
  input  logic                    i_credit_return,
  output logic [CREDIT_WIDTH-1:0] o_credits,
  output logic                    o_busy
);

  resp_state_e           state_r;
  logic [2:0]            cmd_r;
  logic [2:0]            len_r;
  logic [5:0]            tag_r;
  logic [ADDR_BITS-1:0]  base_r;
  logic                  err_r;
  logic [2:0]            beat_r;
  logic [FLIT_WIDTH-1:0] flit_r;
  logic                  flit_valid_r;
  logic                  rx_ready_r;
  logic                  busy_r;

  logic                  credit_nz_s;
  logic                  emit_s;
  logic                  wr_en_s;
  logic [2:0]            hdr_rcmd_s;
  logic [ADDR_BITS-1:0]  mem_addr_s;
  logic [31:0]           rdata_s;

  logic [31:0] mem_r [0:(1<<ADDR_BITS)-1];

  strawman_credit_counter #(
    .MAX   (CREDITS),
    .WIDTH (CREDIT_WIDTH)
  ) u_credits (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (i_credit_return),
    .dec     (emit_s),
    .count   (o_credits),
    .nonzero (credit_nz_s)
  );

  // Burst beats walk the register file and wrap at its depth.
  assign mem_addr_s = base_r + ADDR_BITS'(beat_r);
  assign rdata_s    = mem_r[mem_addr_s];

  // Emit strobe, register-file write enable and response code selection.
  always_comb begin
    emit_s     = 1'b0;
    wr_en_s    = 1'b0;
    hdr_rcmd_s = RCMD_ERR;
    if (((state_r == ST_RESP_HDR) || (state_r == ST_RDATA)) && credit_nz_s) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
    if ((state_r == ST_WDATA) && i_data_valid && !err_r) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (err_r) begin
      hdr_rcmd_s = RCMD_ERR;
    end else if (cmd_r == CMD_READ) begin
      hdr_rcmd_s = RCMD_RD_RESP;
    end else begin
      hdr_rcmd_s = RCMD_WR_ACK;
    end
  end

  // Register file write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[mem_addr_s] <= i_data;
    end
  end

  // Request/response sequencer with registered flit and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cmd_r        <= 3'd0;
      len_r        <= 3'd0;
      tag_r        <= 6'd0;
      base_r       <= {ADDR_BITS{1'b0}};
      err_r        <= 1'b0;
      beat_r       <= 3'd0;
      flit_r       <= {FLIT_WIDTH{1'b0}};
      flit_valid_r <= 1'b0;
      rx_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      flit_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            cmd_r   <= i_cmd;
            len_r   <= i_length;
            tag_r   <= i_feature0;
            busy_r  <= 1'b1;
            state_r <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_addr_valid) begin
            base_r <= i_addr[ADDR_BITS-1:0];
            err_r  <= ((cmd_r != CMD_READ) && (cmd_r != CMD_WRITE)) ||
                      (|i_addr[31:ADDR_BITS]);
            beat_r <= 3'd0;
            // Out-of-range writes still go through WDATA so their beats are drained.
            if (cmd_r == CMD_WRITE) begin
              state_r <= ST_WDATA;
            end else begin
              state_r    <= ST_RESP_HDR;
              rx_ready_r <= 1'b0;
            end
          end
        end
        ST_WDATA: begin
          if (i_data_valid) begin
            if (beat_r == len_r) begin
              beat_r     <= 3'd0;
              state_r    <= ST_RESP_HDR;
              rx_ready_r <= 1'b0;
            end else begin
              beat_r <= beat_r + 3'd1;
            end
          end
        end
        ST_RESP_HDR: begin
          if (emit_s) begin
            flit_valid_r <= 1'b1;
            flit_r       <= FLIT_WIDTH'(build_hdr(hdr_rcmd_s, len_r, tag_r));
            if (!err_r && (cmd_r == CMD_READ)) begin
              state_r <= ST_RDATA;
            end else begin
              state_r    <= ST_IDLE;
              rx_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (emit_s) begin
            flit_valid_r <= 1'b1;
            flit_r       <= FLIT_WIDTH'(build_data({3'b000, beat_r}, rdata_s));
            if (beat_r == len_r) begin
              state_r    <= ST_IDLE;
              rx_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              beat_r <= beat_r + 3'd1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          rx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready   = rx_ready_r;
  assign o_flit       = flit_r;
  assign o_flit_valid = flit_valid_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_strawman_slave_responder.sv
// Scoreboard bench for strawman_slave_responder: a request driver pushes
// expected flits from a word-array model, a monitor pops and compares them.
module tb_strawman_slave_responder;

  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] WR = 3'b010;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_cmd;
  logic        i_cmd_valid;
  logic [2:0]  i_length;
  logic [5:0]  i_feature0;
  logic [31:0] i_addr;
  logic        i_addr_valid;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_rx_ready;
  logic [39:0] o_flit;
  logic        o_flit_valid;
  logic        i_credit_return;
  logic [5:0]  o_credits;
  logic        o_busy;

  strawman_slave_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cmd           (i_cmd),
    .i_cmd_valid     (i_cmd_valid),
    .i_length        (i_length),
    .i_feature0      (i_feature0),
    .i_addr          (i_addr),
    .i_addr_valid    (i_addr_valid),
    .i_data          (i_data),
    .i_data_valid    (i_data_valid),
    .o_rx_ready      (o_rx_ready),
    .o_flit          (o_flit),
    .o_flit_valid    (o_flit_valid),
    .i_credit_return (i_credit_return),
    .o_credits       (o_credits),
    .o_busy          (o_busy)
  );

  typedef struct {
    logic [39:0] flit;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] seen_q[$];
  logic [31:0] mem_m [64];
  logic [31:0] wbuf [8];

  int cyc = 0;
  int flits_seen = 0;
  int returned = 0;
  int manual_target = 0;
  bit auto_ret = 1'b1;
  bit jitter = 1'b0;
  bit tim_ok = 1'b1;
  int mon_tot = 0, mon_pass = 0, dir_tot = 0, dir_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    mon_tot++;
    if (act === exp) mon_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic dchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    dir_tot++;
    if (act === exp) dir_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: credit model every cycle, scoreboard pop on every flit.
  initial begin
    int   cred_m;
    bit   ret_prev;
    exp_t e;
    cred_m = 32;
    ret_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cred_m = 32;
        ret_prev = 1'b0;
        exp_q.delete();
      end else begin
        cred_m = cred_m + int'(ret_prev) - int'(o_flit_valid);
        if (cred_m > 32) cred_m = 32;
        mchk("credits", 64'(o_credits), 64'(cred_m));
        if (o_flit_valid) begin
          flits_seen++;
          seen_q.push_back(o_flit);
          if (exp_q.size() == 0) begin
            mon_tot++;
            $display("FAIL unexpected_flit: got %0h expected none", o_flit);
          end else begin
            e = exp_q.pop_front();
            mchk("flit", 64'(o_flit), 64'(e.flit));
            if (e.cyc >= 0) mchk("flit_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        ret_prev = i_credit_return;
      end
    end
  end

  // FIFO consumer: returns credits up to a target (auto follows flits seen).
  initial begin
    int tgt;
    i_credit_return = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tgt = auto_ret ? flits_seen : manual_target;
      if (!rst_n) begin
        i_credit_return = 1'b0;
        returned = tgt;
      end else if (returned < tgt && (!jitter || $urandom_range(3, 0) != 0)) begin
        i_credit_return = 1'b1;
        returned++;
      end else begin
        i_credit_return = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (o_busy && n < 3000);
    if (o_busy) begin
      dir_tot++;
      $display("FAIL idle_timeout: busy %0b after %0d cycles, required 0", o_busy, n);
    end
  endtask

  task automatic settle();
    wait_idle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_full();
    int n = 0;
    while ((returned != flits_seen || o_credits != 6'd32) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_seen(input string nm, input int idx, input logic [39:0] expv);
    logic [39:0] got;
    got = (idx < seen_q.size()) ? seen_q[idx] : 40'hxxxxxxxxxx;
    dchk(nm, 64'(got), 64'(expv));
  endtask

  // Drive one request and push the response the protocol rules predict.
  task automatic do_req(input logic [2:0] cmd, input logic [2:0] len, input logic [5:0] tag,
                        input logic [31:0] addr, input bit gaps);
    int   c_last, nb, idx;
    bit   err;
    int   rc;
    exp_t e;
    wait_idle();
    i_cmd = cmd; i_length = len; i_feature0 = tag; i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    if (gaps) begin
      i_data_valid = 1'b1; i_data = $urandom; i_cmd_valid = 1'b1; i_cmd = WR;
      @(posedge clk); #1;
      i_data_valid = 1'b0; i_cmd_valid = 1'b0;
    end
    i_addr = addr; i_addr_valid = 1'b1; c_last = cyc;
    @(posedge clk); #1;
    i_addr_valid = 1'b0;
    nb = int'(len) + 1;
    if (cmd == WR) begin
      for (int i = 0; i < nb; i++) begin
        if (gaps && $urandom_range(1, 0) == 1) begin
          i_addr_valid = 1'b1; i_addr = $urandom; i_cmd_valid = 1'b1; i_cmd = RD;
          @(posedge clk); #1;
          i_addr_valid = 1'b0; i_cmd_valid = 1'b0;
        end
        i_data = wbuf[i]; i_data_valid = 1'b1; c_last = cyc;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
      end
    end
    err = !(cmd == RD || cmd == WR) || (addr >= 32'd64);
    rc = err ? 7 : ((cmd == RD) ? 5 : 6);
    e.flit = (40'(rc) << 35) | (40'(len) << 32) | (40'(tag) << 26);
    e.cyc = tim_ok ? c_last + 2 : -1;
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      idx = (int'(addr[5:0]) + i) % 64;
      if (!err && cmd == RD) begin
        e.flit = (40'd2 << 38) | (40'(i) << 32) | 40'(mem_m[idx]);
        e.cyc = tim_ok ? c_last + 3 + i : -1;
        exp_q.push_back(e);
      end
      if (!err && cmd == WR) mem_m[idx] = wbuf[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s, base, pick, len;
    logic [2:0]  cmd;
    logic [31:0] addr;
    rst_n = 1'b0;
    i_cmd = 3'd0; i_cmd_valid = 1'b0; i_length = 3'd0; i_feature0 = 6'd0;
    i_addr = 32'd0; i_addr_valid = 1'b0; i_data = 32'd0; i_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dchk("rst_credits", 64'(o_credits), 64'd32);
    dchk("rst_flit_valid", 64'(o_flit_valid), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dchk("post_rst_credits", 64'(o_credits), 64'd32);
    dchk("post_rst_rx_ready", 64'(o_rx_ready), 64'd1);
    dchk("post_rst_flit_valid", 64'(o_flit_valid), 64'd0);
    dchk("post_rst_busy", 64'(o_busy), 64'd0);
    dchk("post_rst_flit", 64'(o_flit), 64'd0);

    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      do_req(WR, 3'd7, 6'(b), 32'(b * 8), 1'b0);
    end

    // Write then read back with exact flit images.
    settle(); s = seen_q.size();
    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hCAFEF00D;
    do_req(WR, 3'd1, 6'h2A, 32'd4, 1'b0);
    settle();
    dchk("wr_flit_count", 64'(seen_q.size() - s), 64'd1);
    chk_seen("wr_ack_hdr", s, 40'h31A8000000);
    s = seen_q.size();
    do_req(RD, 3'd1, 6'h2A, 32'd4, 1'b0);
    settle();
    dchk("rd_flit_count", 64'(seen_q.size() - s), 64'd3);
    chk_seen("rd_hdr", s, 40'h29A8000000);
    chk_seen("rd_beat0", s + 1, 40'h80DEADBEEF);
    chk_seen("rd_beat1", s + 2, 40'h81CAFEF00D);

    // Address wrap within a burst.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_req(WR, 3'd3, 6'd1, 32'd62, 1'b1);
    settle(); s = seen_q.size();
    do_req(RD, 3'd1, 6'd2, 32'd0, 1'b0);
    settle();
    chk_seen("wrap_beat0", s + 1, 40'h8000000003);
    chk_seen("wrap_beat1", s + 2, 40'h8100000004);

    // Error responses.
    s = seen_q.size();
    do_req(3'b011, 3'd0, 6'd0, 32'd0, 1'b0);
    settle();
    dchk("bad_cmd_count", 64'(seen_q.size() - s), 64'd1);
    chk_seen("bad_cmd_hdr", s, 40'h3800000000);
    s = seen_q.size();
    do_req(RD, 3'd2, 6'd5, 32'h100, 1'b0);
    settle();
    dchk("rd_oor_count", 64'(seen_q.size() - s), 64'd1);
    chk_seen("rd_oor_hdr", s, 40'h3A14000000);
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    s = seen_q.size();
    do_req(WR, 3'd2, 6'd7, 32'h100, 1'b1);
    settle();
    dchk("wr_oor_count", 64'(seen_q.size() - s), 64'd1);
    chk_seen("wr_oor_hdr", s, 40'h3A1C000000);
    s = seen_q.size();
    do_req(RD, 3'd2, 6'd8, 32'd0, 1'b0);
    settle();
    chk_seen("wr_oor_untouched0", s + 1, 40'h8000000003);
    chk_seen("wr_oor_untouched1", s + 2, 40'h8100000004);

    // Credit exhaustion, single-credit release, saturation.
    wait_full();
    dchk("credits_full", 64'(o_credits), 64'd32);
    manual_target = returned; auto_ret = 1'b0; tim_ok = 1'b0;
    base = flits_seen;
    for (int r = 0; r < 4; r++) do_req(RD, 3'd7, 6'(r), 32'(r * 8), 1'b0);
    repeat (40) @(posedge clk);
    #1;
    dchk("drain_flits", 64'(flits_seen - base), 64'd32);
    dchk("drain_credits", 64'(o_credits), 64'd0);
    dchk("drain_valid_low", 64'(o_flit_valid), 64'd0);
    dchk("drain_busy", 64'(o_busy), 64'd1);
    manual_target = manual_target + 1;
    repeat (10) @(posedge clk);
    #1;
    dchk("one_credit_one_flit", 64'(flits_seen - base), 64'd33);
    dchk("one_credit_spent", 64'(o_credits), 64'd0);
    auto_ret = 1'b1;
    settle();
    wait_full();
    dchk("credits_refilled", 64'(o_credits), 64'd32);
    manual_target = returned + 1; auto_ret = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dchk("credit_saturate", 64'(o_credits), 64'd32);
    auto_ret = 1'b1; tim_ok = 1'b1;

    // Reset during the third data beat of an 8-beat read.
    base = flits_seen;
    do_req(RD, 3'd7, 6'd9, 32'd16, 1'b0);
    for (int n = 0; n < 50 && flits_seen < base + 3; n++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    dchk("mid_rst_valid", 64'(o_flit_valid), 64'd0);
    dchk("mid_rst_credits", 64'(o_credits), 64'd32);
    dchk("mid_rst_busy", 64'(o_busy), 64'd0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    s = seen_q.size();
    do_req(RD, 3'd1, 6'd10, 32'd4, 1'b0);
    settle();
    dchk("after_rst_count", 64'(seen_q.size() - s), 64'd3);
    chk_seen("after_rst_hdr", s, 40'h2928000000);
    chk_seen("after_rst_beat0", s + 1, 40'h80DEADBEEF);
    chk_seen("after_rst_beat1", s + 2, 40'h81CAFEF00D);

    // Randomized traffic with jittered credit returns.
    jitter = 1'b1; tim_ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(9, 0);
      if (pick < 4) cmd = RD;
      else if (pick < 8) cmd = WR;
      else begin
        pick = $urandom_range(5, 0);
        cmd = (pick == 0) ? 3'd0 : 3'(pick + 2);
      end
      len = $urandom_range(7, 0);
      if ($urandom_range(9, 0) == 0) addr = (32'h40 << $urandom_range(25, 0)) | 32'($urandom_range(63, 0));
      else addr = 32'($urandom_range(63, 0));
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      do_req(cmd, 3'(len), 6'(k), addr, 1'($urandom_range(1, 0)));
    end
    settle();
    jitter = 1'b0;
    wait_full();
    dchk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    dchk("final_credits", 64'(o_credits), 64'd32);

    $display("%0d/%0d checks passed", mon_pass + dir_pass, mon_tot + dir_tot);
    $finish;
  end

endmodule

// File: doc/strawman_slave_responder.md
# strawman_slave_responder

Slave-side responder for the strawman chiplet protocol. It consumes decoded request fields (cmd, length, feature0, address, write data) from the slave RX FSM and executes reads and writes against a local word-addressed register file. It then emits response flits (header plus read data) toward the slave send-response FIFO. Flow control into that FIFO uses a credit counter.

## Interface
Parameters:
- FLIT_WIDTH, 40, response flit width
- ADDR_BITS, 6, log2 of register-file depth (64 words of 32 bits)
- CREDITS, 32, initial and maximum credit count (equals FIFO_DEPTH)
- CREDIT_WIDTH, 6, width of the credit counter (holds 0..CREDITS)

Ports:
- clk  in  1  single clock for the block
- rst_n  in  1  reset, asynchronous, active-low
- i_cmd  in  3  request command
- i_cmd_valid  in  1  cmd, length and feature0 valid; starts a request
- i_length  in  3  burst length; beats = length+1
- i_feature0  in  6  request tag, echoed in the response
- i_addr  in  32  word address
- i_addr_valid  in  1  address valid
- i_data  in  32  write data beat
- i_data_valid  in  1  write data beat valid
- o_rx_ready  out  1  drives the RX FSM ready input
- o_flit  out  FLIT_WIDTH  response flit
- o_flit_valid  out  1  FIFO write enable, one pulse per flit
- i_credit_return  in  1  one pulse returns one FIFO slot
- o_credits  out  CREDIT_WIDTH  current credit count
- o_busy  out  1  high whenever the state is not IDLE

## Operation
- Command codes:
  - READ = 3'b001
  - WRITE = 3'b010
  - all other codes are unsupported.
- Response header flit fields:
  - [39:38] = 2'b00
  - [37:35] = rcmd: RD_RESP 3'b101, WR_ACK 3'b110, ERR 3'b111
  - [34:32] = echoed length
  - [31:26] = echoed feature0
  - [25:0] = 0
- Data flit fields:
  - [39:38] = 2'b10
  - [37:32] = beat index
  - [31:0] = data
- States and transitions:
  - IDLE: waits for i_cmd_valid, then captures cmd, length and feature0 and goes to ADDR.
  - ADDR: waits for i_addr_valid and captures the address.
    - WRITE goes to WDATA.
    - All other commands go to RESP_HDR.
  - WDATA: accepts length+1 beats on i_data_valid.
    - Beat i writes mem[(base+i) mod 2^ADDR_BITS].
    - After the final beat, goes to RESP_HDR.
  - RESP_HDR: when credits > 0, emits the header.
    - READ without error goes to RDATA.
    - All other cases go to IDLE.
  - RDATA: each cycle with credits > 0, emits beat i = mem[(base+i) mod depth]. After length+1 beats, goes to IDLE.
- Error cases (rcmd = ERR, no data flits):
  - Unsupported cmd.
  - i_addr[31:ADDR_BITS] nonzero. For a WRITE, the data beats are still consumed and discarded.
- Address wrap: addresses wrap modulo the register-file depth within a burst.
- Ignored inputs:
  - Valids arriving in a state that does not expect them.
  - i_cmd_valid while not in IDLE.
- Credits:
  - Each emitted flit decrements the count and each i_credit_return increments it.
  - When both happen in the same cycle, the count is unchanged.
  - A return at CREDITS is ignored (saturates).
- Register file is not reset. Contents are undefined until written.

## Timing
- Reset values: o_flit = 0, o_flit_valid = 0, o_credits = CREDITS, o_busy = 0, state IDLE. o_rx_ready = 1 out of reset.
- o_rx_ready is high in IDLE, ADDR and WDATA, and low in RESP_HDR and RDATA.
- o_flit and o_flit_valid are registered. o_flit_valid is high exactly one cycle per flit.
- Latency:
  - Last request beat (address for reads and errors, final data for writes) in cycle N gives the header in cycle N+2.
  - Read data beats follow in cycles N+3 onward, back to back while credits allow.
- Memory writes take effect at the clock edge of the accepted beat. A read issued later always sees the new data.
- With zero credits, emission stalls in place with no flit loss. It resumes the cycle after a credit return.
- Asserting rst_n low mid-burst immediately forces o_flit_valid low, credits to CREDITS and state to IDLE. The partial response is abandoned.

## Structure
- Shared package strawman_pkg holds:
  - flit type codes (HDR 2'b00, DATA 2'b10)
  - command and response codes
  - the responder state encoding
  - header field bit positions
- Sub-module strawman_credit_counter: saturating up/down counter with a nonzero flag. It is reusable by the TX FSMs.

## Test plan
- Reset: o_credits = 32, o_rx_ready = 1, o_flit_valid = 0, o_busy = 0.
- Write then read:
  - Stimulus: WRITE with length 1, feature0 0x2A, addr 4, data 0xDEADBEEF and 0xCAFEF00D.
  - Write response: header 40'h31A8000000, appearing 2 cycles after the last data beat.
  - Stimulus: READ with length 1, addr 4.
  - Read response: 40'h29A8000000, then 40'h80DEADBEEF, then 40'h81CAFEF00D in consecutive cycles.
- Wrap:
  - Write length 3 at addr 62 with data 1, 2, 3, 4.
  - Read length 1 at addr 0 returns data 3 then 4.
- Credits:
  - With no credit returns, after 32 flits o_credits = 0 and o_flit_valid stays low.
  - A single return pulse releases exactly one flit.
  - A return coinciding with an emit keeps o_credits constant.
  - A return at 32 keeps 32.
- Errors:
  - cmd 3'b011 with length 0 gives only 40'h3800000000.
  - READ of addr 0x100 gives only an ERR header with no data flits.
  - WRITE to addr 0x100 consumes its data beats and gives only an ERR header.
- Reset mid-read:
  - Drop rst_n during RDATA beat 2 of 8.
  - o_flit_valid goes low at once, o_credits = 32, and the next request is serviced normally.
